// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that places ALU0/ALU1/LS0 results onto the two registered CDB slots.
// Latency: a result accepted at one edge is broadcast after the next edge; a three-way loser waits one more cycle.
// Backpressure: src_ready drops for a source whose holding register is full and not granted this cycle, and for all sources during flush.
module cdb_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [2:0]            src_valid,
    input  logic [3*TAG_W-1:0]    src_tag,
    input  logic [3*DATA_W-1:0]   src_data,
    output logic [2:0]            src_ready,
    output logic                  cdb_valid_0,
    output logic                  cdb_valid_1,
    output logic [TAG_W-1:0]      cdb_tag_0,
    output logic [TAG_W-1:0]      cdb_tag_1,
    output logic [DATA_W-1:0]     cdb_data_0,
    output logic [DATA_W-1:0]     cdb_data_1,
    output logic [15:0]           stall_cycles
);

    // One holding register per source.
    logic [2:0]        hold_v;
    logic [TAG_W-1:0]  hold_tag  [3];
    logic [DATA_W-1:0] hold_data [3];

    // Source scanned first; always one of 0..2.
    logic [1:0] rr_ptr;

    logic [1:0] scan [3];
    logic       slot0_v;
    logic       slot1_v;
    logic [1:0] slot0_src;
    logic [1:0] slot1_src;
    logic [2:0] grant;
    logic [2:0] xfer;
    logic [1:0] last_src;
    logic [1:0] rr_next;

    // Scan order starting at rr_ptr and wrapping modulo 3.
    always_comb begin
        scan[0] = rr_ptr;
        scan[1] = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
        scan[2] = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
    end

    // First pending source in scan order gets slot 0, second gets slot 1, third loses.
    always_comb begin
        slot0_v   = 1'b0;
        slot1_v   = 1'b0;
        slot0_src = 2'd0;
        slot1_src = 2'd0;
        grant     = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (hold_v[scan[k]]) begin
                if (!slot0_v) begin
                    slot0_v   = 1'b1;
                    slot0_src = scan[k];
                end else if (!slot1_v) begin
                    slot1_v   = 1'b1;
                    slot1_src = scan[k];
                end
            end
        end
        if (slot0_v) grant[slot0_src] = 1'b1;
        if (slot1_v) grant[slot1_src] = 1'b1;
    end

    // A granted holding register frees up in the same cycle, so it can reload with no bubble.
    always_comb begin
        src_ready = {3{~flush}} & (~hold_v | grant);
        xfer      = src_valid & src_ready;
        last_src  = slot1_v ? slot1_src : slot0_src;
        rr_next   = (last_src == 2'd2) ? 2'd0 : last_src + 2'd1;
    end

    // Holding registers: load on transfer, empty when granted without reload, discard on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                hold_tag[i]  <= '0;
                hold_data[i] <= '0;
            end
        end else if (flush) begin
            hold_v <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (xfer[i]) begin
                    hold_v[i]    <= 1'b1;
                    hold_tag[i]  <= src_tag[i*TAG_W +: TAG_W];
                    hold_data[i] <= src_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end

    // CDB slot registers; an unused slot drives all-zero so stale tags never reach wakeup logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            cdb_valid_0 <= 1'b0;
            cdb_valid_1 <= 1'b0;
            cdb_tag_0   <= '0;
            cdb_tag_1   <= '0;
            cdb_data_0  <= '0;
            cdb_data_1  <= '0;
        end else begin
            cdb_valid_0 <= slot0_v;
            cdb_valid_1 <= slot1_v;
            cdb_tag_0   <= slot0_v ? hold_tag[slot0_src]  : '0;
            cdb_tag_1   <= slot1_v ? hold_tag[slot1_src]  : '0;
            cdb_data_0  <= slot0_v ? hold_data[slot0_src] : '0;
            cdb_data_1  <= slot1_v ? hold_data[slot1_src] : '0;
        end
    end

    // Round-robin pointer moves past the last granted source so a loser is scanned first next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            rr_ptr <= 2'd0;
        end else if (slot0_v) begin
            rr_ptr <= rr_next;
        end
    end

    // Saturating count of cycles where all three results contend; survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'h0000;
        end else if (!flush && (&hold_v) && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'h0001;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized run against a reference model.
// Inputs change 1 time unit after the rising edge; src_ready is sampled just before the edge, CDB outputs 1 unit after it.
// The driver honours backpressure: a presented result stays stable until accepted.
module tb_cdb_arbiter;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [2:0]          src_valid;
    logic [3*TAG_W-1:0]  src_tag;
    logic [3*DATA_W-1:0] src_data;
    logic [2:0]          src_ready;
    logic                cdb_valid_0, cdb_valid_1;
    logic [TAG_W-1:0]    cdb_tag_0, cdb_tag_1;
    logic [DATA_W-1:0]   cdb_data_0, cdb_data_1;
    logic [15:0]         stall_cycles;

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_ready(src_ready),
        .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1),
        .cdb_tag_0(cdb_tag_0), .cdb_tag_1(cdb_tag_1),
        .cdb_data_0(cdb_data_0), .cdb_data_1(cdb_data_1),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a result buffer per source and the arbitration pointer.
    bit [2:0]    m_hv;
    logic [4:0]  m_tag [3];
    logic [15:0] m_data [3];
    int          m_rr;
    int          m_stall;
    logic        e_v0, e_v1;
    logic [4:0]  e_t0, e_t1;
    logic [15:0] e_d0, e_d1;
    logic [2:0]  e_ready;
    logic [2:0]  o_ready;

    task automatic model_reset();
        m_hv = 3'b000; m_rr = 0; m_stall = 0;
        for (int i = 0; i < 3; i++) begin m_tag[i] = '0; m_data[i] = '0; end
        e_v0 = 0; e_v1 = 0; e_t0 = 0; e_t1 = 0; e_d0 = 0; e_d1 = 0; e_ready = 3'b111;
    endtask

    // Leaves the bench 1 unit after a rising edge with reset released.
    task automatic do_reset();
        src_valid = 3'b000; src_tag = '0; src_data = '0; flush = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Drives one cycle of inputs, records observed src_ready, and advances the model across the edge.
    task automatic cycle(input logic [2:0] v, input logic [14:0] t, input logic [47:0] d, input logic fl);
        int g0 = -1;
        int g1 = -1;
        int cnt = 0;
        int s;
        bit [2:0] gr = 3'b000;
        src_valid = v; src_tag = t; src_data = d; flush = fl;
        #3;
        o_ready = src_ready;
        for (int k = 0; k < 3; k++) begin
            s = (m_rr + k) % 3;
            if (m_hv[s]) begin
                if (cnt == 0) g0 = s;
                else if (cnt == 1) g1 = s;
                cnt++;
            end
        end
        if (g0 >= 0) gr[g0] = 1'b1;
        if (g1 >= 0) gr[g1] = 1'b1;
        e_ready = fl ? 3'b000 : (~m_hv | gr);
        @(posedge clk);
        if (fl) begin
            m_hv = 3'b000; m_rr = 0;
            e_v0 = 0; e_v1 = 0; e_t0 = 0; e_t1 = 0; e_d0 = 0; e_d1 = 0;
        end else begin
            e_v0 = (g0 >= 0); e_t0 = e_v0 ? m_tag[g0] : 5'd0; e_d0 = e_v0 ? m_data[g0] : 16'd0;
            e_v1 = (g1 >= 0); e_t1 = e_v1 ? m_tag[g1] : 5'd0; e_d1 = e_v1 ? m_data[g1] : 16'd0;
            if (cnt == 3 && m_stall < 65535) m_stall++;
            if (g0 >= 0) m_rr = (((g1 >= 0) ? g1 : g0) + 1) % 3;
            for (int i = 0; i < 3; i++) begin
                if (v[i] && e_ready[i]) begin
                    m_hv[i] = 1'b1; m_tag[i] = t[i*5 +: 5]; m_data[i] = d[i*16 +: 16];
                end else if (gr[i]) begin
                    m_hv[i] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1, cdb_data_0, cdb_data_1} !== '0) begin
            errors++; $display("FAIL reset_cdb: got v=%b%b t=%0d/%0d d=%h/%h, want all zero",
                cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1, cdb_data_0, cdb_data_1);
        end
        checks++;
        if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
        checks++;
        if (src_ready !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", src_ready); end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr: got %0d want 0", dut.rr_ptr); end
    endtask

    task automatic test_single();
        do_reset();
        cycle(3'b001, {5'd0, 5'd0, 5'd3}, {16'h0, 16'h0, 16'h00AA}, 1'b0);
        checks++;
        if (cdb_valid_0 !== 1'b0) begin errors++; $display("FAIL single_early: got valid0=%b want 0", cdb_valid_0); end
        cycle(3'b000, '0, '0, 1'b0);
        checks++;
        if ({cdb_valid_0, cdb_tag_0, cdb_data_0, cdb_valid_1} !== {1'b1, 5'd3, 16'h00AA, 1'b0}) begin
            errors++; $display("FAIL single_cdb: got v0=%b t0=%0d d0=%h v1=%b want 1/3/00aa/0",
                cdb_valid_0, cdb_tag_0, cdb_data_0, cdb_valid_1);
        end
        checks++;
        if (dut.rr_ptr !== 2'd1) begin errors++; $display("FAIL single_rr: got %0d want 1", dut.rr_ptr); end
        cycle(3'b000, '0, '0, 1'b0);
        checks++;
        if (cdb_valid_0 !== 1'b0) begin errors++; $display("FAIL single_once: got valid0=%b want 0", cdb_valid_0); end
    endtask

    task automatic test_dual();
        do_reset();
        cycle(3'b101, {5'd7, 5'd0, 5'd1}, {16'h7777, 16'h0, 16'h1111}, 1'b0);
        cycle(3'b000, '0, '0, 1'b0);
        checks++;
        if (o_ready !== 3'b111) begin errors++; $display("FAIL dual_ready: got %b want 111", o_ready); end
        checks++;
        if ({cdb_valid_0, cdb_tag_0, cdb_data_0, cdb_valid_1, cdb_tag_1, cdb_data_1} !==
            {1'b1, 5'd1, 16'h1111, 1'b1, 5'd7, 16'h7777}) begin
            errors++; $display("FAIL dual_cdb: got %b/%0d/%h %b/%0d/%h want 1/1/1111 1/7/7777",
                cdb_valid_0, cdb_tag_0, cdb_data_0, cdb_valid_1, cdb_tag_1, cdb_data_1);
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL dual_rr: got %0d want 0", dut.rr_ptr); end
    endtask

    task automatic test_triple();
        int seq [3];
        int seen [24];
        int p0 [4] = '{0, 2, 1, 0};
        int p1 [4] = '{1, 0, 2, 1};
        logic [2:0] rdy_tbl [4] = '{3'b011, 3'b101, 3'b110, 3'b011};
        logic [2:0]  v;
        logic [14:0] t;
        logic [47:0] d;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 3; i++) seq[i] = 0;
        for (int i = 0; i < 24; i++) seen[i] = 0;
        for (int c = 0; c < 7; c++) begin
            v = (c < 4) ? 3'b111 : 3'b000;
            for (int s = 0; s < 3; s++) begin
                t[s*5 +: 5]   = 5'(s * 8 + seq[s]);
                d[s*16 +: 16] = 16'hA000 + 16'(s * 8 + seq[s]);
            end
            cycle(v, t, d, 1'b0);
            for (int s = 0; s < 3; s++) if (v[s] && o_ready[s]) seq[s]++;
            if (cdb_valid_0 && cdb_tag_0 < 24) seen[cdb_tag_0]++;
            if (cdb_valid_1 && cdb_tag_1 < 24) seen[cdb_tag_1]++;
            checks++;
            if ({cdb_valid_0, cdb_tag_0, cdb_data_0, cdb_valid_1, cdb_tag_1, cdb_data_1} !==
                {e_v0, e_t0, e_d0, e_v1, e_t1, e_d1}) begin
                errors++; $display("FAIL triple_model c%0d: got %b/%0d %b/%0d want %b/%0d %b/%0d", c,
                    cdb_valid_0, cdb_tag_0, cdb_valid_1, cdb_tag_1, e_v0, e_t0, e_v1, e_t1);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (o_ready !== rdy_tbl[c-1]) begin
                    errors++; $display("FAIL triple_ready c%0d: got %b want %b", c, o_ready, rdy_tbl[c-1]);
                end
                checks++;
                if (!cdb_valid_0 || !cdb_valid_1 || int'(cdb_tag_0 / 8) != p0[c-1] || int'(cdb_tag_1 / 8) != p1[c-1]) begin
                    errors++; $display("FAIL triple_pair c%0d: got v=%b%b src %0d,%0d want {%0d,%0d}", c,
                        cdb_valid_0, cdb_valid_1, cdb_tag_0 / 8, cdb_tag_1 / 8, p0[c-1], p1[c-1]);
                end
            end
        end
        checks++;
        if (stall_cycles !== 16'd4) begin errors++; $display("FAIL triple_stall: got %0d want 4", stall_cycles); end
        for (int i = 0; i < 24; i++)
            if (seen[i] != (((i / 8) < 3 && (i % 8) < seq[i / 8]) ? 1 : 0)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL triple_scoreboard: got %0d lost/duplicated tags want 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] want [3] = '{5'd10, 5'd11, 5'd12};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c < 3) cycle(3'b010, {5'd0, want[c], 5'd0}, {16'h0, 16'hB000 + 16'(c), 16'h0}, 1'b0);
            else       cycle(3'b000, '0, '0, 1'b0);
            if (c < 3) begin
                checks++;
                if (o_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready c%0d: got %b want 1", c, o_ready[1]); end
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if ({cdb_valid_0, cdb_tag_0, cdb_data_0} !== {1'b1, want[c-1], 16'hB000 + 16'(c - 1)}) begin
                    errors++; $display("FAIL b2b_cdb c%0d: got %b/%0d/%h want 1/%0d/%h", c,
                        cdb_valid_0, cdb_tag_0, cdb_data_0, want[c-1], 16'hB000 + 16'(c - 1));
                end
            end
        end
        checks++;
        if (cdb_valid_0 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid0=%b want 0", cdb_valid_0); end
    endtask

    task automatic test_flush();
        do_reset();
        cycle(3'b011, {5'd0, 5'd2, 5'd1}, {16'h0, 16'h2222, 16'h1111}, 1'b0);
        cycle(3'b100, {5'd9, 5'd0, 5'd0}, {16'h9999, 16'h0, 16'h0}, 1'b1);
        checks++;
        if (o_ready !== 3'b000) begin errors++; $display("FAIL flush_ready: got %b want 000", o_ready); end
        checks++;
        if ({cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1, cdb_data_0, cdb_data_1} !== '0) begin
            errors++; $display("FAIL flush_cdb: got v=%b%b t=%0d/%0d want zero", cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1);
        end
        checks++;
        if (dut.hold_v !== 3'b000) begin errors++; $display("FAIL flush_hold: got %b want 000", dut.hold_v); end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL flush_rr: got %0d want 0", dut.rr_ptr); end
        cycle(3'b000, '0, '0, 1'b0);
        checks++;
        if (cdb_valid_0 !== 1'b0 || cdb_valid_1 !== 1'b0) begin
            errors++; $display("FAIL flush_drop: got v=%b%b want 00", cdb_valid_0, cdb_valid_1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 3; c++)
            cycle(3'b111, {5'd20 + 5'(c), 5'd10 + 5'(c), 5'(c)}, {16'h3000, 16'h2000, 16'h1000}, 1'b0);
        checks++;
        if (stall_cycles !== 16'(m_stall) || m_stall == 0) begin
            errors++; $display("FAIL areset_pre: got stall %0d want %0d (nonzero)", stall_cycles, m_stall);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1, cdb_data_0, cdb_data_1} !== '0) begin
            errors++; $display("FAIL areset_cdb: got v=%b%b t=%0d/%0d want zero", cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1);
        end
        checks++;
        if (stall_cycles !== 16'd0) begin errors++; $display("FAIL areset_stall: got %0d want 0", stall_cycles); end
        checks++;
        if (dut.hold_v !== 3'b000) begin errors++; $display("FAIL areset_hold: got %b want 000", dut.hold_v); end
        src_valid = 3'b000;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cycle(3'b000, '0, '0, 1'b0);
        checks++;
        if (cdb_valid_0 !== 1'b0 || cdb_valid_1 !== 1'b0) begin
            errors++; $display("FAIL areset_nobcast: got v=%b%b want 00", cdb_valid_0, cdb_valid_1);
        end
    endtask

    task automatic test_random();
        logic [2:0]  pv = 3'b000;
        logic [14:0] pt = '0;
        logic [47:0] pd = '0;
        bit [2:0]    need_new = 3'b111;
        logic        fl;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 3; s++) begin
                if (need_new[s]) begin
                    pv[s]          = ($urandom_range(0, 3) != 0);
                    pt[s*5 +: 5]   = 5'($urandom);
                    pd[s*16 +: 16] = 16'($urandom);
                end
            end
            fl = ($urandom_range(0, 19) == 0);
            cycle(pv, pt, pd, fl);
            need_new = ~pv | o_ready;
            checks++;
            if (o_ready !== e_ready) begin errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, o_ready, e_ready); end
            checks++;
            if ({cdb_valid_0, cdb_tag_0, cdb_data_0, cdb_valid_1, cdb_tag_1, cdb_data_1} !==
                {e_v0, e_t0, e_d0, e_v1, e_t1, e_d1}) begin
                errors++; $display("FAIL rand_cdb c%0d: got %b/%0d/%h %b/%0d/%h want %b/%0d/%h %b/%0d/%h", c,
                    cdb_valid_0, cdb_tag_0, cdb_data_0, cdb_valid_1, cdb_tag_1, cdb_data_1,
                    e_v0, e_t0, e_d0, e_v1, e_t1, e_d1);
            end
            checks++;
            if (stall_cycles !== 16'(m_stall)) begin errors++; $display("FAIL rand_stall c%0d: got %0d want %0d", c, stall_cycles, m_stall); end
            checks++;
            if (int'(dut.rr_ptr) != m_rr) begin errors++; $display("FAIL rand_rr c%0d: got %0d want %0d", c, dut.rr_ptr, m_rr); end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; src_valid = 3'b000; src_tag = '0; src_data = '0;
        model_reset();
        test_reset();
        test_single();
        test_dual();
        test_triple();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
